// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: target end of the CPU memory bus.
// Decodes the CPU address into work RAM, the PPU register window, PRG ROM
// or open bus. Keeps the open-bus latch. Runs the $4014 OAM DMA engine,
// which stalls the CPU and copies one 256-byte page into sprite OAM.
module cpu_bus_responder #(
  parameter int          RAM_AW  = 11,
  parameter int          PRG_AW  = 15,
  parameter logic [15:0] DMA_REG = 16'h4014
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       addr,
  input  logic              write,
  input  logic [7:0]        d_out,
  input  logic              sync,
  output logic [7:0]        d_in,
  output logic              ready,
  output logic [2:0]        ppu_reg,
  output logic              ppu_cs,
  output logic              ppu_we,
  output logic [7:0]        ppu_wdata,
  input  logic [7:0]        ppu_rdata,
  output logic [PRG_AW-1:0] prg_addr,
  input  logic [7:0]        prg_data,
  output logic [7:0]        oam_addr,
  output logic [7:0]        oam_data,
  output logic              oam_we
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_GET,
    S_PUT
  } dma_state_t;

  dma_state_t  state, state_next;
  logic [7:0]  dma_page;
  logic [7:0]  dma_idx;
  logic [7:0]  dma_data;
  logic [7:0]  bus_latch;
  logic        parity;

  logic [7:0]  ram [0:(1<<RAM_AW)-1];

  logic        cpu_cycle;
  logic        dma_get;
  logic        bus_active;
  logic [15:0] ea;
  logic        sel_ram;
  logic        sel_ppu;
  logic        sel_prg;
  logic [7:0]  fetched;
  logic        cpu_write;
  logic        dma_trigger;

  // sync only matters to an external debug parity check; it drives nothing here
  logic        unused_sync;
  assign unused_sync = sync;

  // The CPU owns the bus while idle; a DMA GET cycle drives its own address.
  // HALT, ALIGN and PUT cycles select nothing on the bus.
  assign cpu_cycle   = (state == S_IDLE);
  assign dma_get     = (state == S_GET);
  assign bus_active  = cpu_cycle | dma_get;
  assign ea          = dma_get ? {dma_page, dma_idx} : addr;
  assign sel_ram     = bus_active & (ea[15:13] == 3'b000);
  assign sel_ppu     = bus_active & (ea[15:13] == 3'b001);
  assign sel_prg     = bus_active & ea[15];
  assign cpu_write   = cpu_cycle & write & ~reset;
  assign dma_trigger = cpu_write & (addr == DMA_REG);

  // Read mux: the selected source, otherwise the last value seen on the bus
  always_comb begin
    fetched = bus_latch;
    if (sel_ram) begin
      fetched = ram[ea[RAM_AW-1:0]];
    end else if (sel_ppu) begin
      fetched = ppu_rdata;
    end else if (sel_prg) begin
      fetched = prg_data;
    end
  end

  // Outputs are forced to their idle values while reset is asserted, so a
  // reset in the middle of a DMA releases the CPU in the same cycle
  assign ready     = reset | cpu_cycle;
  assign d_in      = reset ? 8'h00 : fetched;
  assign ppu_cs    = ~reset & sel_ppu;
  assign ppu_we    = ppu_cs & write & cpu_cycle;
  assign ppu_reg   = reset ? 3'd0 : ea[2:0];
  assign ppu_wdata = reset ? 8'h00 : d_out;
  assign prg_addr  = reset ? '0 : ea[PRG_AW-1:0];
  assign oam_we    = ~reset & (state == S_PUT);
  assign oam_addr  = reset ? 8'h00 : dma_idx;
  assign oam_data  = reset ? 8'h00 : dma_data;

  // Work RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (cpu_write && sel_ram) begin
      ram[ea[RAM_AW-1:0]] <= d_out;
    end
  end

  // DMA next-state logic; an odd HALT cycle costs one extra ALIGN cycle
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (dma_trigger) state_next = S_HALT;
      S_HALT:  state_next = parity ? S_ALIGN : S_GET;
      S_ALIGN: state_next = S_GET;
      S_GET:   state_next = S_PUT;
      S_PUT:   state_next = (dma_idx == 8'hFF) ? S_IDLE : S_GET;
      default: state_next = S_IDLE;
    endcase
  end

  // State, DMA datapath, parity and open-bus latch registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      dma_page  <= 8'h00;
      dma_idx   <= 8'h00;
      dma_data  <= 8'h00;
      bus_latch <= 8'h00;
      parity    <= 1'b0;
    end else begin
      state  <= state_next;
      parity <= ~parity;
      if (dma_trigger) begin
        dma_page <= d_out;
        dma_idx  <= 8'h00;
      end
      if (dma_get) begin
        dma_data <= fetched;
      end
      if (state == S_PUT) begin
        dma_idx <= dma_idx + 8'd1;
      end
      if (cpu_cycle) begin
        bus_latch <= write ? d_out : fetched;
      end else if (dma_get) begin
        bus_latch <= fetched;
      end
    end
  end

endmodule
